hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage LEG ARM core. It consumes the register-match flags produced by the address path and the stage control bits from the controller. It produces operand-forwarding selects and every stage stall/flush, and these feed back into the address path, datapath and controller. Sequential state covers a multi-cycle multiply occupancy counter and a pending-flush latch, so that branches resolved during a memory stall are not lost.

---
 rtl/leg_hazard_pkg.sv | 17 +
 rtl/hazard_mulfsm.sv | 61 ++++++
 rtl/hazard_unit.sv | 113 +++++++++++
 tb/tb_hazard_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/leg_hazard_pkg.sv
// Shared types for the LEG hazard controller: forwarding selects and multiply FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package leg_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_t;

endpackage

// File: rtl/hazard_mulfsm.sv
// Multiply occupancy tracker: holds Execute busy for the cycles after a multiply's first cycle.
// Latency: mul_busy_o rises the cycle after an accepted start and lasts MUL_LAT-1 unstalled cycles.
// Backpressure: stall_i (memory freeze) holds both state and counter unchanged.
module hazard_mulfsm
    import leg_hazard_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic stall_i,
    output logic mul_busy_o
);

    localparam int CNT_W = $clog2(MUL_LAT);

    mul_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers; reset drops any multiply in flight immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a start while busy is the same held instruction, so it is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MUL_IDLE: begin
                if (start_i && !stall_i) begin
                    state_d = MUL_BUSY;
                    cnt_d   = CNT_W'(MUL_LAT - 2);
                end
            end
            MUL_BUSY: begin
                if (!stall_i) begin
                    if (cnt_q == '0) begin
                        state_d = MUL_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = MUL_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign mul_busy_o = (state_q == MUL_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard controller: forwarding selects, stage stalls/flushes, pending branch flush.
// Latency: all outputs combinational from inputs and state (0 cycles); multiply holds Execute MUL_LAT cycles.
// Backpressure: DataStallM freezes every stage and all internal state. Macro HAZARD_FORWARD_EN enables forwarding.
module hazard_unit
    import leg_hazard_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Match_1E_M,
    input  logic       Match_1E_W,
    input  logic       Match_2E_M,
    input  logic       Match_2E_W,
    input  logic       Match_1D_E,
    input  logic       Match_2D_E,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MulStartE,
    input  logic       BranchTakenE,
    input  logic       DataStallM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       StallW,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       FlushW
);

    fwd_sel_t fwd_a, fwd_b;
    logic     ex_hz;
    logic     ldstall;
    logic     mul_busy;
    logic     flush_pend_q, flush_pend_d;
    logic     br_flush;

    hazard_mulfsm #(
        .MUL_LAT (MUL_LAT)
    ) u_mulfsm (
        .clk_i      (clk),
        .rst_ni     (reset),
        .start_i    (MulStartE),
        .stall_i    (DataStallM),
        .mul_busy_o (mul_busy)
    );

    // Operand sourcing: forward with Memory over Writeback, or stall until the producer retires.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        ex_hz = 1'b0;
`ifdef HAZARD_FORWARD_EN
        if (Match_1E_M && RegWriteM)      fwd_a = FWD_M;
        else if (Match_1E_W && RegWriteW) fwd_a = FWD_W;
        if (Match_2E_M && RegWriteM)      fwd_b = FWD_M;
        else if (Match_2E_W && RegWriteW) fwd_b = FWD_W;
`else
        ex_hz = ((Match_1E_M || Match_2E_M) && RegWriteM) ||
                ((Match_1E_W || Match_2E_W) && RegWriteW);
`endif
    end

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;
    assign ldstall   = (Match_1D_E || Match_2D_E) && MemtoRegE;
    assign br_flush  = BranchTakenE || flush_pend_q;

    // A branch seen while memory is frozen is remembered and replayed on the first free cycle.
    always_comb begin
        flush_pend_d = DataStallM ? (flush_pend_q || BranchTakenE) : 1'b0;
    end

    // Pending-flush latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) flush_pend_q <= 1'b0;
        else        flush_pend_q <= flush_pend_d;
    end

    // Stall/flush merge: memory freeze overrides all; a stalled Execute never gets a bubble.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        StallW = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (DataStallM) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            StallW = 1'b1;
        end else begin
            StallE = mul_busy || ex_hz;
            StallF = ldstall || StallE;
            StallD = ldstall || StallE;
            FlushM = StallE;
            FlushD = br_flush;
            FlushE = (ldstall || br_flush) && !StallE;
        end
    end

    assign FlushW = 1'b0;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a cycle-level behavioural model and per-cycle compare.
// Latency: inputs applied 1 time unit after posedge; literal checks 2 units later; model compare on negedge.
// Backpressure: DataStallM sequences exercised directly.
module tb_hazard_unit;

    localparam int MUL_LAT = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W;
    logic Match_1D_E, Match_2D_E, RegWriteM, RegWriteW;
    logic MemtoRegE, MulStartE, BranchTakenE, DataStallM;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, StallW;
    logic FlushD, FlushE, FlushM, FlushW;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: remaining multiply-hold cycles and remembered branch flush
    int   mul_left = 0;
    logic pend = 1'b0;

    hazard_unit #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset),
        .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
        .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
        .Match_1D_E(Match_1D_E), .Match_2D_E(Match_2D_E),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MulStartE(MulStartE),
        .BranchTakenE(BranchTakenE), .DataStallM(DataStallM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] dut_vec();
        return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
                FlushD, FlushE, FlushM, FlushW};
    endfunction

    // Expected outputs from the hazard rules, given current inputs and model state.
    function automatic logic [12:0] model_vec();
        logic [1:0] fa, fb;
        logic hz, ld, busy, br;
        logic sf, sd, se, sm, sw, fd, fe, fm;
        fa = 2'd0; fb = 2'd0; hz = 1'b0;
`ifdef HAZARD_FORWARD_EN
        if (Match_1E_M & RegWriteM)      fa = 2'd2;
        else if (Match_1E_W & RegWriteW) fa = 2'd1;
        if (Match_2E_M & RegWriteM)      fb = 2'd2;
        else if (Match_2E_W & RegWriteW) fb = 2'd1;
`else
        hz = ((Match_1E_M | Match_2E_M) & RegWriteM) | ((Match_1E_W | Match_2E_W) & RegWriteW);
`endif
        ld   = (Match_1D_E | Match_2D_E) & MemtoRegE;
        busy = (mul_left > 0);
        br   = BranchTakenE | pend;
        if (DataStallM) begin
            {sf, sd, se, sm, sw} = 5'b11111;
            {fd, fe, fm} = 3'b000;
        end else begin
            se = busy | hz;
            sf = ld | se;
            sd = ld | se;
            sm = 1'b0;
            sw = 1'b0;
            fm = se;
            fd = br;
            fe = (ld | br) & ~se;
        end
        return {fa, fb, sf, sd, se, sm, sw, fd, fe, fm, 1'b0};
    endfunction

    // Model state advance on the same edge as the DUT.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_left <= 0;
            pend     <= 1'b0;
        end else begin
            if (!DataStallM) begin
                if (mul_left > 0)   mul_left <= mul_left - 1;
                else if (MulStartE) mul_left <= MUL_LAT - 1;
            end
            pend <= DataStallM ? (pend | BranchTakenE) : 1'b0;
        end
    end

    task automatic chkv(input string nm, input logic [12:0] act, input logic [12:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chkv("model", dut_vec(), model_vec());
    end

    task automatic clr_in();
        Match_1E_M = 0; Match_1E_W = 0; Match_2E_M = 0; Match_2E_W = 0;
        Match_1D_E = 0; Match_2D_E = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MulStartE = 0; BranchTakenE = 0; DataStallM = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        clr_in();
    endtask

    initial begin
        clr_in();
        repeat (2) @(posedge clk);
        #2;
        chkv("reset_zero", dut_vec(), 13'd0);
        nxt(); reset = 1'b1; #1;
        chkv("post_reset_zero", dut_vec(), 13'd0);

        // forwarding priority
        nxt(); Match_1E_M = 1; RegWriteM = 1; Match_1E_W = 1; RegWriteW = 1; #1;
`ifdef HAZARD_FORWARD_EN
        chk2("fwdA_mem", ForwardAE, 2'b10);
        chk1("fwd_no_stallE", StallE, 1'b0);
`else
        chk2("nofwd_A_rf", ForwardAE, 2'b00);
        chk1("nofwd_stallE", StallE, 1'b1);
        chk1("nofwd_flushM", FlushM, 1'b1);
`endif
        nxt(); Match_1E_M = 1; Match_1E_W = 1; RegWriteW = 1; Match_2E_W = 1; #1;
`ifdef HAZARD_FORWARD_EN
        chk2("fwdA_wb", ForwardAE, 2'b01);
        chk2("fwdB_wb", ForwardBE, 2'b01);
`else
        chk1("nofwd_wb_stallE", StallE, 1'b1);
        chk2("nofwd_B_rf", ForwardBE, 2'b00);
`endif

        // load-use
        nxt(); MemtoRegE = 1; Match_2D_E = 1; #1;
        chk1("ld_StallF", StallF, 1'b1);
        chk1("ld_StallD", StallD, 1'b1);
        chk1("ld_FlushE", FlushE, 1'b1);
        chk1("ld_StallE", StallE, 1'b0);
        nxt(); #1;
        chkv("ld_after", dut_vec(), 13'd0);

        // multiply, undisturbed
        nxt(); MulStartE = 1; #1;
        chk1("mul_start_StallE", StallE, 1'b0);
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            nxt(); #1;
            chk1("mul_busy_StallE", StallE, 1'b1);
            chk1("mul_busy_FlushM", FlushM, 1'b1);
        end
        nxt(); #1;
        chkv("mul_done", dut_vec(), 13'd0);

        // multiply with a two-cycle memory freeze in the middle
        nxt(); MulStartE = 1; #1;
        nxt(); #1;
        chk1("mulds_b1_StallE", StallE, 1'b1);
        repeat (2) begin
            nxt(); DataStallM = 1; #1;
            chk1("mulds_frz_StallE", StallE, 1'b1);
            chk1("mulds_frz_StallW", StallW, 1'b1);
            chk1("mulds_frz_FlushM", FlushM, 1'b0);
        end
        nxt(); #1;
        chk1("mulds_b2_StallE", StallE, 1'b1);
        chk1("mulds_b2_FlushM", FlushM, 1'b1);
        nxt(); #1;
        chk1("mulds_done_StallE", StallE, 1'b0);

        // branch, immediate
        nxt(); BranchTakenE = 1; #1;
        chk1("br_FlushD", FlushD, 1'b1);
        chk1("br_FlushE", FlushE, 1'b1);

        // branch during a memory freeze
        repeat (3) begin
            nxt(); BranchTakenE = 1; DataStallM = 1; #1;
            chk1("brds_FlushD", FlushD, 1'b0);
            chk1("brds_FlushE", FlushE, 1'b0);
        end
        nxt(); #1;
        chk1("brpend_FlushD", FlushD, 1'b1);
        chk1("brpend_FlushE", FlushE, 1'b1);
        nxt(); #1;
        chk1("brpend_clr_FlushD", FlushD, 1'b0);
        chk1("brpend_clr_FlushE", FlushE, 1'b0);

        // load-use while multiply is busy: no bubble into a held Execute
        nxt(); MulStartE = 1; #1;
        nxt(); MemtoRegE = 1; Match_1D_E = 1; #1;
        chk1("comb_StallE", StallE, 1'b1);
        chk1("comb_FlushE", FlushE, 1'b0);
        chk1("comb_StallF", StallF, 1'b1);
        nxt(); #1;
        nxt(); #1;
        chkv("comb_done", dut_vec(), 13'd0);

        // asynchronous reset mid-multiply, then a full restart
        nxt(); MulStartE = 1; #1;
        nxt(); #1;
        chk1("rst_pre_StallE", StallE, 1'b1);
        reset = 1'b0; #1;
        chkv("rst_async_zero", dut_vec(), 13'd0);
        nxt(); reset = 1'b1; MulStartE = 1; #1;
        chk1("restart_StallE", StallE, 1'b0);
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            nxt(); #1;
            chk1("restart_busy_StallE", StallE, 1'b1);
        end
        nxt(); #1;
        chkv("restart_done", dut_vec(), 13'd0);

        nxt(); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
